// File: rtl/awg_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package awg_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two circular byte buffer; show-ahead read of the head entry.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full buffer refuses writes even when a read frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a bit-serial framer.
module uart_transmitter
  import awg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_tx_state_t            state;
  logic [CNT_W-1:0]          baud_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      last_baud;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign last_baud = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  // Head is taken when leaving IDLE or at the final STOP cycle, giving gap-free frames.
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || (state == STOP && last_baud));
  assign busy      = (state != IDLE) || (fifo_count != '0);

  byte_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Shift register holds payload only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      shift_reg <= fifo_rd_data;
    end else if (state == DATA && last_baud && bit_idx != 3'(UART_DATA_BITS - 1)) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!fifo_empty) begin
            state   <= START;
            uart_tx <= 1'b0;
          end else begin
            uart_tx <= 1'b1;
          end
        end
        START: begin
          if (last_baud) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (last_baud) begin
            baud_cnt <= '0;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (last_baud) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (!fifo_empty) begin
              state   <= START;
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a reference serial receiver model.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int         rx_frame_err = 0;

  uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(output bit timed_out);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    timed_out = busy;
    tick_n(2);
  endtask

  // Line level expected during bit period k (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Reference receiver: finds the start edge, samples each bit mid-period.
  initial begin
    int         phase;
    int         k;
    logic [7:0] sh;
    phase = -1;
    sh = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        phase = -1;
      end else if (phase < 0) begin
        if (uart_tx == 1'b0) phase = 0;
      end else begin
        phase++;
      end
      if (phase >= 0 && (phase % CPB) == CPB / 2) begin
        k = phase / CPB;
        if (k >= 1 && k <= 8) begin
          sh[k-1] = uart_tx;
        end else if (k == 9) begin
          rx_q.push_back(sh);
          if (uart_tx !== 1'b1) rx_frame_err++;
          phase = -1;
        end
      end
    end
  end

  task automatic test_reset();
    bit to;
    #2 rst_n = 1'b0;
    tick_n(3);
    checks++;
    if (uart_tx !== 1'b1) begin failures++; $display("FAIL rst_uart_tx got=%b want=1", uart_tx); end
    checks++;
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL rst_fifo_count got=%0d want=0", fifo_count); end
    checks++;
    if (tx_ready !== 1'b1) begin failures++; $display("FAIL rst_tx_ready got=%b want=1", tx_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    rst_n    = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) begin failures++; $display("FAIL first_push_count got=%0d want=1", fifo_count); end
    wait_idle(to);
    checks++;
    if (to) begin failures++; $display("FAIL first_push_idle_timeout got=busy want=idle"); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
      failures++;
      $display("FAIL first_push_rx got_size=%0d want=1 byte 5a", rx_q.size());
    end
  endtask

  task automatic test_single_byte();
    int bad;
    int first_bad;
    rx_q.delete();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    checks++;
    if (uart_tx !== 1'b1 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL a5_accept got uart_tx=%b count=%0d want 1/1", uart_tx, fifo_count);
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (uart_tx !== exp_bit(8'hA5, i / CPB)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL a5_frame got=%0d wrong cycles (first at %0d) want=0", bad, first_bad);
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL a5_busy_in_stop got=%b want=1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      failures++;
      $display("FAIL a5_after_stop got busy=%b uart_tx=%b want 0/1", busy, uart_tx);
    end
  endtask

  task automatic test_back_to_back();
    int   bad;
    int   first_bad;
    logic s39;
    logic s40;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1) begin failures++; $display("FAIL b2b_count got=%0d want=1", fifo_count); end
    bad = 0;
    first_bad = -1;
    s39 = 1'bx;
    s40 = 1'bx;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) tick();
      if (i == 39) s39 = uart_tx;
      if (i == 40) s40 = uart_tx;
      if (uart_tx !== exp_bit((i < 40) ? 8'h00 : 8'hFF, (i % 40) / CPB)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_frames got=%0d wrong cycles (first at %0d) want=0", bad, first_bad);
    end
    checks++;
    if (s39 !== 1'b1 || s40 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_gap got stop=%b start=%b want 1/0", s39, s40);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_simultaneous();
    bit         to;
    bit         ok;
    logic [7:0] exp_q[4];
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    rx_q.delete();
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    tick();
    tx_data  = 8'h22;
    tick();
    tx_data  = 8'h33;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_setup_count got=%0d want=2", fifo_count); end
    tick_n(38);
    checks++;
    if (fifo_count !== 3'd2 || uart_tx !== 1'b1) begin
      failures++;
      $display("FAIL simul_last_stop got count=%0d uart_tx=%b want 2/1", fifo_count, uart_tx);
    end
    tx_data  = 8'h44;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd2) begin failures++; $display("FAIL simul_count got=%0d want=2", fifo_count); end
    checks++;
    if (uart_tx !== 1'b0) begin failures++; $display("FAIL simul_next_start got=%b want=0", uart_tx); end
    wait_idle(to);
    ok = !to && rx_q.size() == 4;
    for (int i = 0; i < 4 && ok; i++) if (rx_q[i] !== exp_q[i]) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL simul_order got_size=%0d timeout=%0d want 11,22,33,44", rx_q.size(), to);
    end
  endtask

  task automatic test_full();
    bit to;
    bit ok;
    int not_ready;
    rx_q.delete();
    not_ready = 0;
    tx_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tx_data = 8'(k);
      if (!tx_ready) not_ready++;
      tick();
    end
    checks++;
    if (not_ready != 0) begin failures++; $display("FAIL full_fill_ready got=%0d stalls want=0", not_ready); end
    checks++;
    if (fifo_count !== 3'd4 || tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_state got count=%0d ready=%b want 4/0", fifo_count, tx_ready);
    end
    tx_data = 8'h06;
    tick_n(36);
    checks++;
    if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_blocked got=%0d want=4", fifo_count); end
    tick();
    checks++;
    if (fifo_count !== 3'd3 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_edge got count=%0d ready=%b want 3/1", fifo_count, tx_ready);
    end
    tick();
    tx_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d want=4", fifo_count); end
    wait_idle(to);
    ok = !to && rx_q.size() == 6;
    for (int i = 0; i < 6 && ok; i++) if (rx_q[i] !== 8'(i + 1)) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_order got_size=%0d timeout=%0d want 01..06", rx_q.size(), to);
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    int busys;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    tick();
    tx_data  = 8'h55;
    tick();
    tx_data  = 8'h66;
    tick();
    tx_valid = 1'b0;
    tick_n(16);
    checks++;
    if (fifo_count !== 3'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_before got count=%0d busy=%b want 2/1", fifo_count, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_async got tx=%b count=%0d busy=%b ready=%b want 1/0/0/1",
               uart_tx, fifo_count, busy, tx_ready);
    end
    tick_n(2);
    rx_q.delete();
    rst_n = 1'b1;
    lows = 0;
    busys = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    checks++;
    if (lows != 0 || busys != 0 || rx_q.size() != 0) begin
      failures++;
      $display("FAIL rmid_quiet got lows=%0d busy=%0d rx=%0d want 0/0/0", lows, busys, rx_q.size());
    end
  endtask

  task automatic test_wrap();
    bit to;
    bit ok;
    int stalls;
    int n;
    rx_q.delete();
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      while (fifo_count >= 3'd2 && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) stalls++;
      tx_data  = 8'h10 + 8'(k);
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
    end
    checks++;
    if (stalls != 0) begin failures++; $display("FAIL wrap_stall got=%0d want=0", stalls); end
    wait_idle(to);
    ok = !to && rx_q.size() == 10;
    for (int i = 0; i < 10 && ok; i++) if (rx_q[i] !== 8'h10 + 8'(i)) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_order got_size=%0d timeout=%0d want 10..19", rx_q.size(), to);
    end
    checks++;
    if (rx_frame_err != 0) begin failures++; $display("FAIL stop_bits got=%0d bad want=0", rx_frame_err); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_simultaneous();
    test_full();
    test_reset_mid_frame();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
